// File: rtl/usb_rx_packet_ctrl.sv
// USB receive packet sequencer: PID decode, token match and payload routing.
// Runs on clk48_i and drives endpoint commit/rollback and receiver resets.
module usb_rx_packet_ctrl #(
  parameter int ENDPOINTS     = 4,
  parameter int TOKEN_TIMEOUT = 1024
) (
  input  logic       clk48_i,
  input  logic       rstn_i,
  input  logic [6:0] deviceAddr_i,
  input  logic       rxDataValid_i,
  input  logic [7:0] rxData_i,
  input  logic       rxIsLastByte_i,
  input  logic       keepPacket_i,
  output logic       rxAcceptNewData_o,
  output logic       rxRST_o,
  output logic       tokenValid_o,
  output logic [3:0] tokenPid_o,
  output logic [3:0] tokenEp_o,
  output logic       handshakeValid_o,
  output logic [3:0] handshakePid_o,
  output logic [3:0] epSel_o,
  output logic       epWrValid_o,
  output logic [7:0] epWrData_o,
  input  logic       epWrReady_i,
  output logic       epCommit_o,
  output logic       epRollback_o,
  output logic [3:0] dataPid_o
);

  localparam int CW = $clog2(TOKEN_TIMEOUT) + 1;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  typedef enum logic [2:0] {
    IDLE, TOK1, TOK2, DATA, DROP, FINISH
  } state_t;

  state_t         state_q, state_d;
  logic           live_q;
  logic [3:0]     pid_q, pid_d;
  logic [6:0]     addr_q, addr_d;
  logic           ep0_q, ep0_d;
  logic           pend_q, pend_d;
  logic [3:0]     pendEp_q, pendEp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tokV_q, tokV_d;
  logic [3:0]     tokPid_q, tokPid_d;
  logic [3:0]     tokEp_q, tokEp_d;
  logic           hsV_q, hsV_d;
  logic [3:0]     hsPid_q, hsPid_d;
  logic           cmt_q, cmt_d;
  logic           rb_q, rb_d;
  logic [3:0]     dPid_q, dPid_d;

  logic       accept;
  logic       hs;
  logic [3:0] pidIn;
  logic [3:0] epFull;
  logic       isTok;
  logic       isData;
  logic       isHsk;
  logic       epOk;

  always_comb begin
    accept = 1'b0;
    unique case (state_q)
      IDLE, TOK1, TOK2, DROP: accept = 1'b1;
      DATA:                   accept = epWrReady_i;
      default:                accept = 1'b0;
    endcase
  end

  // live_q holds accept low while in reset so every output reads 0 there
  assign rxAcceptNewData_o = accept & live_q;
  assign hs     = rxDataValid_i & rxAcceptNewData_o;
  assign pidIn  = rxData_i[3:0];
  assign epFull = {rxData_i[2:0], ep0_q};
  assign epOk   = ({1'b0, epFull} < 5'(ENDPOINTS));

  assign isTok  = (pidIn == PID_OUT) | (pidIn == PID_IN) |
                  (pidIn == PID_SETUP) | (pidIn == PID_SOF);
  assign isData = (pidIn[1:0] == 2'b11);
  assign isHsk  = (pidIn == PID_ACK) | (pidIn == PID_NAK) |
                  (pidIn == PID_STALL);

  always_comb begin
    state_d  = state_q;
    pid_d    = pid_q;
    addr_d   = addr_q;
    ep0_d    = ep0_q;
    pend_d   = pend_q;
    pendEp_d = pendEp_q;
    cnt_d    = cnt_q;
    tokV_d   = 1'b0;
    tokPid_d = tokPid_q;
    tokEp_d  = tokEp_q;
    hsV_d    = 1'b0;
    hsPid_d  = hsPid_q;
    cmt_d    = 1'b0;
    rb_d     = 1'b0;
    dPid_d   = dPid_q;

    if (pend_q && state_q != DATA) begin
      if (cnt_q == CW'(TOKEN_TIMEOUT - 1)) begin
        pend_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (state_q == FINISH) begin
      state_d = IDLE;
    end else if (hs) begin
      unique case (state_q)
        IDLE: begin
          pid_d = pidIn;
          if (rxIsLastByte_i) begin
            state_d = FINISH;
            if (isHsk && keepPacket_i) begin
              hsV_d   = 1'b1;
              hsPid_d = pidIn;
            end else if (isData && pend_d) begin
              pend_d = 1'b0;
              cmt_d  = keepPacket_i;
              rb_d   = ~keepPacket_i;
              if (keepPacket_i) dPid_d = pidIn;
            end
          end else if (isTok) begin
            state_d = TOK1;
          end else if (isData && pend_d) begin
            state_d = DATA;
          end else begin
            state_d = DROP;
          end
        end
        TOK1: begin
          addr_d  = rxData_i[6:0];
          ep0_d   = rxData_i[7];
          state_d = rxIsLastByte_i ? FINISH : TOK2;
        end
        TOK2: begin
          if (!rxIsLastByte_i) begin
            state_d = DROP;
          end else begin
            state_d = FINISH;
            if (keepPacket_i && addr_q == deviceAddr_i &&
                epOk && pid_q != PID_SOF) begin
              tokV_d   = 1'b1;
              tokPid_d = pid_q;
              tokEp_d  = epFull;
              if (pid_q == PID_OUT || pid_q == PID_SETUP) begin
                pend_d   = 1'b1;
                pendEp_d = epFull;
                cnt_d    = '0;
              end
            end
          end
        end
        DATA: begin
          if (rxIsLastByte_i) begin
            state_d = FINISH;
            pend_d  = 1'b0;
            cmt_d   = keepPacket_i;
            rb_d    = ~keepPacket_i;
            if (keepPacket_i) dPid_d = pid_q;
          end
        end
        DROP: begin
          if (rxIsLastByte_i) state_d = FINISH;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk48_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      live_q   <= 1'b0;
      pid_q    <= '0;
      addr_q   <= '0;
      ep0_q    <= 1'b0;
      pend_q   <= 1'b0;
      pendEp_q <= '0;
      cnt_q    <= '0;
      tokV_q   <= 1'b0;
      tokPid_q <= '0;
      tokEp_q  <= '0;
      hsV_q    <= 1'b0;
      hsPid_q  <= '0;
      cmt_q    <= 1'b0;
      rb_q     <= 1'b0;
      dPid_q   <= '0;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      pid_q    <= pid_d;
      addr_q   <= addr_d;
      ep0_q    <= ep0_d;
      pend_q   <= pend_d;
      pendEp_q <= pendEp_d;
      cnt_q    <= cnt_d;
      tokV_q   <= tokV_d;
      tokPid_q <= tokPid_d;
      tokEp_q  <= tokEp_d;
      hsV_q    <= hsV_d;
      hsPid_q  <= hsPid_d;
      cmt_q    <= cmt_d;
      rb_q     <= rb_d;
      dPid_q   <= dPid_d;
    end
  end

  assign rxRST_o          = (state_q == FINISH);
  assign tokenValid_o     = tokV_q;
  assign tokenPid_o       = tokPid_q;
  assign tokenEp_o        = tokEp_q;
  assign handshakeValid_o = hsV_q;
  assign handshakePid_o   = hsPid_q;
  assign epSel_o          = (state_q == DATA) ? pendEp_q : 4'h0;
  assign epWrValid_o      = (state_q == DATA) & rxDataValid_i;
  assign epWrData_o       = (state_q == DATA) ? rxData_i : 8'h00;
  assign epCommit_o       = cmt_q;
  assign epRollback_o     = rb_q;
  assign dataPid_o        = dPid_q;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Scoreboard bench for usb_rx_packet_ctrl: directed packets drive queues,
// a monitor pops expected tokens, handshakes, beats and commits.
module tb_usb_rx_packet_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [6:0] devAddr;
  logic       rxDataValid_i;
  logic [7:0] rxData_i;
  logic       rxIsLastByte_i;
  logic       keepPacket_i;
  logic       rxAcceptNewData_o;
  logic       rxRST_o;
  logic       tokenValid_o;
  logic [3:0] tokenPid_o;
  logic [3:0] tokenEp_o;
  logic       handshakeValid_o;
  logic [3:0] handshakePid_o;
  logic [3:0] epSel_o;
  logic       epWrValid_o;
  logic [7:0] epWrData_o;
  logic       epWrReady_i;
  logic       epCommit_o;
  logic       epRollback_o;
  logic [3:0] dataPid_o;

  always #5 clk = ~clk;

  usb_rx_packet_ctrl #(.ENDPOINTS(4), .TOKEN_TIMEOUT(1024)) dut (
    .clk48_i(clk),
    .rstn_i(rstn),
    .deviceAddr_i(devAddr),
    .rxDataValid_i(rxDataValid_i),
    .rxData_i(rxData_i),
    .rxIsLastByte_i(rxIsLastByte_i),
    .keepPacket_i(keepPacket_i),
    .rxAcceptNewData_o(rxAcceptNewData_o),
    .rxRST_o(rxRST_o),
    .tokenValid_o(tokenValid_o),
    .tokenPid_o(tokenPid_o),
    .tokenEp_o(tokenEp_o),
    .handshakeValid_o(handshakeValid_o),
    .handshakePid_o(handshakePid_o),
    .epSel_o(epSel_o),
    .epWrValid_o(epWrValid_o),
    .epWrData_o(epWrData_o),
    .epWrReady_i(epWrReady_i),
    .epCommit_o(epCommit_o),
    .epRollback_o(epRollback_o),
    .dataPid_o(dataPid_o)
  );

  logic [34:0] allOut;
  assign allOut = {rxAcceptNewData_o, rxRST_o, tokenValid_o, tokenPid_o,
                   tokenEp_o, handshakeValid_o, handshakePid_o, epSel_o,
                   epWrValid_o, epWrData_o, epCommit_o, epRollback_o,
                   dataPid_o};

  int checks = 0;
  int failures = 0;
  int expRst = 0;
  int rstSeen = 0;
  logic prevRst = 1'b0;

  logic [7:0]  tokQ[$];
  logic [3:0]  hskQ[$];
  logic [11:0] wrQ[$];
  logic [3:0]  cmQ[$];
  logic [3:0]  rbQ[$];
  logic        rdyQ[$];
  logic [7:0]  pkt[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    logic [11:0] w;
    forever begin
      @(negedge clk);
      #2;
      if (tokenValid_o) begin
        if (tokQ.size() > 0) chk("token", {tokenPid_o, tokenEp_o}, tokQ.pop_front());
        else chk("token_unexpected", tokenValid_o, 0);
      end
      if (handshakeValid_o) begin
        if (hskQ.size() > 0) chk("handshake", handshakePid_o, hskQ.pop_front());
        else chk("handshake_unexpected", handshakeValid_o, 0);
      end
      if (epWrValid_o && rxAcceptNewData_o) begin
        w = {epSel_o, epWrData_o};
        if (wrQ.size() > 0) chk("wr_beat", w, wrQ.pop_front());
        else chk("wr_unexpected", w, 0);
      end
      if (epCommit_o) begin
        if (cmQ.size() > 0) chk("commit_dataPid", dataPid_o, cmQ.pop_front());
        else chk("commit_unexpected", epCommit_o, 0);
      end
      if (epRollback_o) begin
        if (rbQ.size() > 0) chk("rollback_dataPid", dataPid_o, rbQ.pop_front());
        else chk("rollback_unexpected", epRollback_o, 0);
      end
      if (epCommit_o && epRollback_o) chk("commit_and_rollback", 1'b1, 0);
      if (rxRST_o) begin
        rstSeen++;
        chk("rxrst_one_cycle", prevRst, 0);
      end
      prevRst = rxRST_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last,
                           input logic keep, input bit rc);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    rxDataValid_i = 1'b1;
    rxData_i = b;
    rxIsLastByte_i = last;
    keepPacket_i = keep;
    while (!acc && n < 64) begin
      epWrReady_i = (rdyQ.size() > 0) ? rdyQ.pop_front() : 1'b1;
      #1;
      acc = rxAcceptNewData_o;
      if (rc) chk("accept_follows_ready", rxAcceptNewData_o, epWrReady_i);
      @(negedge clk);
      n++;
    end
    if (!acc) chk("byte_accept_timeout", acc, 1);
  endtask

  task automatic send(input logic keep, input bit rc);
    for (int i = 0; i < pkt.size(); i++)
      send_byte(pkt[i], i == pkt.size() - 1, keep, rc && i > 0);
    rxDataValid_i = 1'b0;
    rxIsLastByte_i = 1'b0;
    keepPacket_i = 1'b0;
    epWrReady_i = 1'b1;
    pkt.delete();
    expRst++;
    idle(3);
  endtask

  initial begin
    rstn = 1'b0;
    devAddr = 7'd5;
    rxDataValid_i = 1'b0;
    rxData_i = 8'h00;
    rxIsLastByte_i = 1'b0;
    keepPacket_i = 1'b0;
    epWrReady_i = 1'b1;
    #2;
    chk("reset_outputs", allOut, 0);
    idle(2);
    rstn = 1'b1;
    idle(2);

    // OUT ep2, then DATA0 commit
    tokQ.push_back({4'h1, 4'h2});
    pkt = '{8'hE1, 8'h05, 8'hE9};
    send(1'b1, 1'b0);
    wrQ.push_back({4'h2, 8'h11});
    wrQ.push_back({4'h2, 8'h22});
    wrQ.push_back({4'h2, 8'h33});
    cmQ.push_back(4'h3);
    pkt = '{8'hC3, 8'h11, 8'h22, 8'h33};
    send(1'b1, 1'b1);

    // OUT ep2, DATA0 with bad packet -> rollback, dataPid stays 3
    tokQ.push_back({4'h1, 4'h2});
    pkt = '{8'hE1, 8'h05, 8'h01};
    send(1'b1, 1'b0);
    wrQ.push_back({4'h2, 8'h44});
    wrQ.push_back({4'h2, 8'h55});
    wrQ.push_back({4'h2, 8'h66});
    rbQ.push_back(4'h3);
    pkt = '{8'hC3, 8'h44, 8'h55, 8'h66};
    send(1'b0, 1'b1);

    // wrong address, DATA1 dropped
    pkt = '{8'hE1, 8'h06, 8'h01};
    send(1'b1, 1'b0);
    pkt = '{8'h4B, 8'h77, 8'h88};
    send(1'b1, 1'b0);

    // SETUP ep1, DATA1 with ready stalls
    tokQ.push_back({4'hD, 4'h1});
    pkt = '{8'h2D, 8'h85, 8'h00};
    send(1'b1, 1'b0);
    wrQ.push_back({4'h1, 8'hA1});
    wrQ.push_back({4'h1, 8'hB2});
    wrQ.push_back({4'h1, 8'hC3});
    wrQ.push_back({4'h1, 8'hD4});
    cmQ.push_back(4'hB);
    rdyQ = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    pkt = '{8'h4B, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send(1'b1, 1'b1);

    // ACK accepted, NAK with bad packet ignored
    hskQ.push_back(4'h2);
    pkt = '{8'hD2};
    send(1'b1, 1'b0);
    pkt = '{8'h5A};
    send(1'b0, 1'b0);

    // SOF and ep>=ENDPOINTS produce no token
    pkt = '{8'hA5, 8'h05, 8'h01};
    send(1'b1, 1'b0);
    pkt = '{8'hE1, 8'h05, 8'h02};
    send(1'b1, 1'b0);

    // OUT ep3, zero-length DATA0 commit
    tokQ.push_back({4'h1, 4'h3});
    pkt = '{8'hE1, 8'h85, 8'h01};
    send(1'b1, 1'b0);
    cmQ.push_back(4'h3);
    pkt = '{8'hC3};
    send(1'b1, 1'b0);

    // token ages out
    tokQ.push_back({4'h1, 4'h2});
    pkt = '{8'hE1, 8'h05, 8'h01};
    send(1'b1, 1'b0);
    idle(1030);
    pkt = '{8'hC3, 8'h99};
    send(1'b1, 1'b0);

    // reset in the middle of a DATA packet
    tokQ.push_back({4'h1, 4'h2});
    pkt = '{8'hE1, 8'h05, 8'h01};
    send(1'b1, 1'b0);
    wrQ.push_back({4'h2, 8'hEE});
    send_byte(8'h4B, 1'b0, 1'b1, 1'b0);
    send_byte(8'hEE, 1'b0, 1'b1, 1'b1);
    rxData_i = 8'hFF;
    epWrReady_i = 1'b0;
    #1;
    chk("midreset_wrvalid_before", epWrValid_o, 1);
    rstn = 1'b0;
    #1;
    chk("midreset_outputs", allOut, 0);
    rxDataValid_i = 1'b0;
    epWrReady_i = 1'b1;
    idle(3);
    rstn = 1'b1;
    idle(3);

    hskQ.push_back(4'hE);
    pkt = '{8'h1E};
    send(1'b1, 1'b0);
    idle(5);

    chk("rxrst_count", rstSeen, expRst);
    chk("tokQ_empty", tokQ.size(), 0);
    chk("hskQ_empty", hskQ.size(), 0);
    chk("wrQ_empty", wrQ.size(), 0);
    chk("cmQ_empty", cmQ.size(), 0);
    chk("rbQ_empty", rbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
